// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: glyph table,
// blank pattern, PWM phase width and the "all anodes off" pattern.
package seg7_pkg;

  // PWM phase counter width: 16 brightness steps per digit slot.
  localparam int PHASE_W = 4;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Widest anode bus supported; the top slices off NUM_DIGITS bits.
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  // Active-low glyphs indexed by 4-bit value, segs[0]=A .. segs[6]=G.
  // Entries 10-15 are A, b, C, d, E, F.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 4-bit value to active-low 7-segment glyph. With hex_mode
// low, values above 9 have no decimal glyph and are shown dark.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_mode,
  output logic [6:0] segs
);

  // Table lookup, with non-decimal values blanked outside hex mode.
  always_comb begin
    segs = GLYPH_TABLE[value];
    if (!hex_mode && (value > 4'd9)) begin
      segs = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment driver with per-digit decimal points,
// leading-zero blanking, 16-step PWM brightness and a frame-coherent
// snapshot of the displayed value so a frame never mixes old and new data.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000,
  parameter int HEX_MODE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]        pre_cnt;
  logic [PHASE_W-1:0]      phase;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_lzb;
  logic                    load_pending;

  logic                    tick;
  logic                    phase_last;
  logic                    idx_last;
  logic                    load;
  logic [3:0]              cur_value;
  logic                    cur_blank;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   anodes_next;

  assign tick       = (pre_cnt == PRE_W'(CLK_DIV - 1));
  assign phase_last = (phase == {PHASE_W{1'b1}});
  assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
  // A new snapshot is taken as the scan wraps back to digit 0, or on the
  // very first tick after reset so the display does not wait a whole frame.
  assign load       = tick && ((phase_last && idx_last) || load_pending);

  // Prescaler, PWM phase and digit index counters; they free-run even
  // while the display is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      phase   <= '0;
      idx     <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        phase   <= phase + 1'b1;
        if (phase_last) begin
          idx <= idx_last ? '0 : idx + 1'b1;
        end
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Frame-coherent capture of the displayed value, dots and blanking mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_digits  <= '0;
      snap_dp      <= '0;
      snap_lzb     <= 1'b0;
      load_pending <= 1'b1;
    end else if (load) begin
      snap_digits  <= digits;
      snap_dp      <= dp_in;
      snap_lzb     <= lzb;
      load_pending <= 1'b0;
    end
  end

  // Leading-zero mask: digit i (i>0) is dark when it and every digit to
  // its left are zero. Digit 0 always shows, so zero reads as "0".
  always_comb begin
    logic zeros_left;
    zeros_left = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_left = zeros_left && (snap_digits[4*i +: 4] == 4'h0);
      if (i > 0) begin
        blank_mask[i] = snap_lzb && zeros_left;
      end
    end
  end

  assign cur_value = snap_digits[{idx, 2'b00} +: 4];
  assign cur_blank = blank_mask[idx];

  seg7_glyph_decode u_decode (
    .value    (cur_value),
    .hex_mode (HEX_MODE != 0),
    .segs     (glyph)
  );

  // Only the active digit's anode may go low, and only during its PWM on-time.
  always_comb begin
    anodes_next = ANODES_OFF[NUM_DIGITS-1:0];
    if (en && (phase <= bright)) begin
      anodes_next[idx] = 1'b0;
    end
  end

  // Registered pin drivers, one clock behind the scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes      <= ANODES_OFF[NUM_DIGITS-1:0];
      segs        <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anodes      <= anodes_next;
      segs        <= cur_blank ? SEG_BLANK : glyph;
      dp          <= cur_blank ? 1'b1 : ~snap_dp[idx];
      frame_start <= load;
    end
  end

endmodule
